// File: rtl/axis_fir_symm_mac.sv
// Time-multiplexed symmetric FIR: one pre-adder and one multiplier reused over
// U=(taps+1)/2 cycles per sample, AXI-Stream in/out, double-buffered coefficients.
`timescale 1ns/1ps
module axis_fir_symm_mac #(
  parameter int inout_width               = 24,
  parameter int inout_decimal_width       = 23,
  parameter int coefficient_width         = 24,
  parameter int coefficient_decimal_width = 23,
  parameter int taps                      = 33,
  localparam int U  = (taps + 1) / 2,
  localparam int KW = (U > 1) ? $clog2(U) : 1
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic [inout_width-1:0]       s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [inout_width-1:0]       m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         coef_wr_en,
  input  logic [KW-1:0]                coef_wr_addr,
  input  logic [coefficient_width-1:0] coef_wr_data,
  input  logic                         coef_commit
);
  localparam int IW    = inout_width;
  localparam int CW    = coefficient_width;
  localparam int PW    = IW + 1 + CW;
  localparam int AW    = PW + $clog2(U) + 1;
  localparam int XW    = $clog2(taps);
  localparam int SHIFT = (inout_decimal_width + coefficient_decimal_width) - inout_decimal_width;
  localparam bit ODD   = (taps % 2) == 1;
  localparam logic signed [AW-1:0] SMAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t r_state, w_state_nx;

  logic signed [IW-1:0] r_x     [taps];
  logic signed [CW-1:0] r_c_sh  [U];
  logic signed [CW-1:0] r_c_act [U];
  logic signed [AW-1:0] r_acc;
  logic [KW-1:0]        r_k;
  logic                 r_live, r_commit_pend, r_tlast_lat;
  logic [IW-1:0]        r_tdata;
  logic                 r_tlast;

  logic [XW-1:0]        w_ka, w_kb;
  logic signed [IW-1:0] w_xa, w_xb;
  logic signed [CW-1:0] w_c;
  logic signed [IW:0]   w_pre;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_acc_nx, w_shift;
  logic [IW-1:0]        w_sat;
  logic                 w_accept, w_last_k, w_centre, w_copy;

  assign w_accept = s_axis_tvalid && s_axis_tready;
  assign w_last_k = (r_k == KW'(U - 1));
  assign w_copy   = r_commit_pend && (r_state == S_IDLE);

  // Symmetric pair x[k] + x[taps-1-k]; the odd-length centre tap stands alone.
  assign w_ka     = XW'(r_k);
  assign w_kb     = XW'(taps - 1) - w_ka;
  assign w_xa     = r_x[w_ka];
  assign w_xb     = r_x[w_kb];
  assign w_c      = r_c_act[r_k];
  assign w_centre = ODD && w_last_k;
  assign w_pre    = (IW+1)'(w_xa) + (w_centre ? '0 : (IW+1)'(w_xb));
  assign w_prod   = PW'(w_pre) * PW'(w_c);
  assign w_acc_nx = r_acc + AW'(w_prod);
  assign w_shift  = w_acc_nx >>> SHIFT;
  assign w_sat    = (w_shift > SMAX) ? SMAX[IW-1:0] :
                    (w_shift < SMIN) ? SMIN[IW-1:0] : w_shift[IW-1:0];

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_state_nx = S_MAC;
      S_MAC:   if (w_last_k)      w_state_nx = S_OUT;
      S_OUT:   if (m_axis_tready) w_state_nx = S_IDLE;
      default:                    w_state_nx = S_IDLE;
    endcase
  end

  // r_live keeps tready low until the first clock after reset release.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (r_state)
      S_IDLE:  s_axis_tready = r_live;
      S_OUT:   m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < taps; i++) r_x[i] <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_live      <= 1'b0;
      r_tlast_lat <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        for (int i = taps - 1; i > 0; i--) r_x[i] <= r_x[i-1];
        r_x[0]      <= s_axis_tdata;
        r_tlast_lat <= s_axis_tlast;
        r_acc       <= '0;
        r_k         <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= w_acc_nx;
        r_k   <= r_k + KW'(1);
        if (w_last_k) begin
          r_tdata <= w_sat;
          r_tlast <= r_tlast_lat;
        end
      end
    end
  end

  // Active bank only loads in IDLE so an in-flight sample sees one coefficient set.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < U; i++) begin
        r_c_sh[i]  <= '0;
        r_c_act[i] <= '0;
      end
      r_commit_pend <= 1'b0;
    end else begin
      if (coef_wr_en && (int'(coef_wr_addr) < U)) r_c_sh[coef_wr_addr] <= coef_wr_data;
      if (w_copy) r_c_act <= r_c_sh;
      r_commit_pend <= coef_commit || (r_commit_pend && !w_copy);
    end
  end

  assign m_axis_tdata = r_tdata;
  assign m_axis_tlast = r_tlast;
endmodule
